// File: rtl/axi_sw_pkg.sv
// Shared types and sizing for the switch-driven AXI-lite master.
// Latency and backpressure: none, this file holds declarations only.
package axi_sw_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR,
    DONE
  } state_t;

  // Width of a counter that runs from 0 up to cycles-1.
  function automatic int cnt_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/axi_sw_master_if.sv
// Valid/ready bus between the switch master and the axi register slave.
// Latency and backpressure: wires only; each channel stalls on its own ready/valid.
interface axi_sw_master_if;
  import axi_sw_pkg::*;

  logic              ms_arvalid;
  logic              sm_arready;
  logic              ms_rready;
  logic              sm_rvalid;
  logic              ms_awvalid;
  logic              sm_awready;
  logic              ms_wvalid;
  logic              sm_wready;
  logic [ADDR_W-1:0] SWM_arADDR;
  logic [DATA_W-1:0] SWM_wdata;

  modport master (
    output ms_arvalid, ms_rready, ms_awvalid, ms_wvalid, SWM_arADDR, SWM_wdata,
    input  sm_arready, sm_rvalid, sm_awready, sm_wready
  );

  modport slave (
    input  ms_arvalid, ms_rready, ms_awvalid, ms_wvalid, SWM_arADDR, SWM_wdata,
    output sm_arready, sm_rvalid, sm_awready, sm_wready
  );

endinterface

// File: rtl/sw_debounce.sv
// Button synchronizer + debouncer emitting a one-cycle pulse on an accepted rising level.
// Latency: pulse 2+DEBOUNCE_CYCLES cycles after the input settles; no backpressure.
module sw_debounce
  import axi_sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic req
);

  localparam int               CNT_W    = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;

  // The counter only runs while the synchronized input disagrees with the
  // accepted level, so any bounce back restarts it and it never passes CNT_LAST.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      req     <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
      req     <= 1'b0;
      if (sync_q2 == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q   <= '0;
        level_q <= sync_q2;
        req     <= sync_q2;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_sw_master.sv
// Button-driven master issuing one read or write per press; optional timeout via AXI_SW_MASTER_TIMEOUT_EN.
// Latency: valid one cycle after acceptance, done >=3 (read) / >=2 (write) cycles; holds valids until ready.
module axi_sw_master
  import axi_sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_rd,
  input  logic                 btn_wr,
  input  logic [ADDR_W-1:0]    sw_addr,
  input  logic [DATA_W-1:0]    sw_data,
  axi_sw_master_if.master      bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_t            state_q, state_d;
  logic              rd_req, wr_req;
  logic              accept_rd, accept_wr, accept_pend;
  logic [ADDR_W-1:0] addr_q, pend_addr_q;
  logic [DATA_W-1:0] data_q, pend_data_q;
  logic              pend_q, aw_done_q, w_done_q, err_q;
  logic              ar_hs, r_hs, aw_hs, w_hs;

  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rd (
    .clk(clk), .reset(reset), .btn(btn_rd), .req(rd_req)
  );
  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_wr (
    .clk(clk), .reset(reset), .btn(btn_wr), .req(wr_req)
  );

  assign bus.ms_arvalid = (state_q == RD_ADDR);
  assign bus.ms_rready  = (state_q == RD_DATA);
  assign bus.ms_awvalid = (state_q == WR) && !aw_done_q;
  assign bus.ms_wvalid  = (state_q == WR) && !w_done_q;
  assign bus.SWM_arADDR = addr_q;
  assign bus.SWM_wdata  = data_q;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign err            = err_q;

  assign ar_hs = bus.ms_arvalid && bus.sm_arready;
  assign r_hs  = bus.ms_rready  && bus.sm_rvalid;
  assign aw_hs = bus.ms_awvalid && bus.sm_awready;
  assign w_hs  = bus.ms_wvalid  && bus.sm_wready;

`ifdef AXI_SW_MASTER_TIMEOUT_EN
  localparam int               TMO_W    = cnt_w(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q;
  logic             timeout;
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    accept_rd   = 1'b0;
    accept_wr   = 1'b0;
    accept_pend = 1'b0;
`ifdef AXI_SW_MASTER_TIMEOUT_EN
    timeout     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // A write deferred behind a simultaneous read outranks new presses.
        if (pend_q) begin
          accept_pend = 1'b1;
          state_d     = WR;
        end else if (rd_req) begin
          accept_rd = 1'b1;
          state_d   = RD_ADDR;
        end else if (wr_req) begin
          accept_wr = 1'b1;
          state_d   = WR;
        end
      end
      RD_ADDR: if (ar_hs) state_d = RD_DATA;
      RD_DATA: if (r_hs)  state_d = DONE;
      WR:      if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef AXI_SW_MASTER_TIMEOUT_EN
    if ((state_q inside {RD_ADDR, RD_DATA, WR}) && (state_d == state_q) && (tmo_q == TMO_LAST)) begin
      timeout = 1'b1;
      state_d = IDLE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      err_q       <= 1'b0;
`ifdef AXI_SW_MASTER_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (accept_rd) begin
        addr_q <= sw_addr;
        err_q  <= 1'b0;
        if (wr_req) begin
          pend_q      <= 1'b1;
          pend_addr_q <= sw_addr;
          pend_data_q <= sw_data;
        end
      end
      if (accept_wr) begin
        addr_q <= sw_addr;
        data_q <= sw_data;
        err_q  <= 1'b0;
      end
      if (accept_pend) begin
        addr_q <= pend_addr_q;
        data_q <= pend_data_q;
        pend_q <= 1'b0;
        err_q  <= 1'b0;
      end
      if (state_q == WR) begin
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_hs)  w_done_q  <= 1'b1;
      end else begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
`ifdef AXI_SW_MASTER_TIMEOUT_EN
      if (state_d != state_q)   tmo_q <= '0;
      else if (tmo_q != TMO_LAST) tmo_q <= tmo_q + 1'b1;
      if (timeout) begin
        err_q  <= 1'b1;
        pend_q <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_axi_sw_master.sv
// Scoreboard bench: presses queue expected transactions, a negedge monitor checks the bus.
module tb_axi_sw_master;
  import axi_sw_pkg::*;

  localparam int DEB = 4;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_rd = 1'b0;
  logic       btn_wr = 1'b0;
  logic [3:0] sw_addr = '0;
  logic [3:0] sw_data = '0;
  logic       busy, done, err;

  axi_sw_master_if bus();

  axi_sw_master #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .btn_rd(btn_rd), .btn_wr(btn_wr),
    .sw_addr(sw_addr), .sw_data(sw_data), .bus(bus),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_wr;
    logic [3:0] addr;
    logic [3:0] data;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_done = 0;
  int   done_cnt = 0;
  int   slave_mode = 1;  // 0 random, 1 all ready, 2 all stalled, 3 staggered w, 4 ar stalled
  bit   aw_first = 0;
  int   ar_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got nothing expected event at %0t", name, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 400) begin
      tick(1);
      n++;
      if (busy) quiet = 0;
      else quiet++;
    end
    if (quiet < 3) fail_now("idle_wait");
  endtask

  task automatic press(input bit rd, input bit wr, input logic [3:0] a,
                       input logic [3:0] d, input bit expect_done);
    txn_t t;
    if (expect_done) begin
      if (rd) begin t.is_wr = 0; t.addr = a; t.data = '0; exp_q.push_back(t); exp_done++; end
      if (wr) begin t.is_wr = 1; t.addr = a; t.data = d;  exp_q.push_back(t); exp_done++; end
    end
    sw_addr = a;
    sw_data = d;
    btn_rd  = rd;
    btn_wr  = wr;
    tick(DEB + 8);
    btn_rd = 1'b0;
    btn_wr = 1'b0;
    tick(DEB + 4);
    wait_idle();
  endtask

  // Slave responder: drives readies just after each rising edge.
  initial begin
    int stag = 0;
    bus.sm_arready = 1'b0;
    bus.sm_rvalid  = 1'b0;
    bus.sm_awready = 1'b0;
    bus.sm_wready  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (busy) stag++;
      else stag = 0;
      case (slave_mode)
        0: begin
          bus.sm_arready = 1'($urandom_range(0, 1));
          bus.sm_rvalid  = 1'($urandom_range(0, 1));
          bus.sm_awready = 1'($urandom_range(0, 1));
          bus.sm_wready  = 1'($urandom_range(0, 1));
        end
        1: begin
          bus.sm_arready = 1'b1; bus.sm_rvalid = 1'b1;
          bus.sm_awready = 1'b1; bus.sm_wready = 1'b1;
        end
        2: begin
          bus.sm_arready = 1'b0; bus.sm_rvalid = 1'b0;
          bus.sm_awready = 1'b0; bus.sm_wready = 1'b0;
        end
        3: begin
          bus.sm_arready = 1'b1; bus.sm_rvalid = 1'b1;
          bus.sm_awready = 1'b1; bus.sm_wready = (stag >= 3);
        end
        default: begin
          bus.sm_arready = 1'b0; bus.sm_rvalid = 1'b1;
          bus.sm_awready = 1'b1; bus.sm_wready = 1'b1;
        end
      endcase
    end
  end

  // Monitor: samples mid-cycle; what it sees is what the next rising edge acts on.
  initial begin
    int   cyc = 0;
    int   rise_cyc = 0;
    int   ar_hi_cnt = 0;
    bit   seen_aw = 0, seen_w = 0, last_wr = 0, err_rise;
    bit   p_arvalid = 0, p_arready = 0, p_rready = 0, p_rvalid = 0;
    bit   p_awvalid = 0, p_awready = 0, p_wvalid = 0, p_wready = 0;
    bit   p_done = 0, p_busy = 0, p_err = 0;
    logic [3:0] p_addr = '0, p_data = '0;
    txn_t t;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        seen_aw = 0; seen_w = 0;
        p_arvalid = 0; p_rready = 0; p_awvalid = 0; p_wvalid = 0;
        p_done = 0; p_busy = 0; p_err = 0;
      end else begin
        err_rise = err && !p_err;
        if (p_arvalid && !p_arready && !err_rise) begin
          chk("ar_hold", bus.ms_arvalid, 1);
          chk("ar_addr_stable", bus.SWM_arADDR, p_addr);
        end
        if (p_rready && !p_rvalid && !err_rise) chk("r_hold", bus.ms_rready, 1);
        if (p_awvalid && !p_awready && !err_rise) begin
          chk("aw_hold", bus.ms_awvalid, 1);
          chk("aw_addr_stable", bus.SWM_arADDR, p_addr);
        end
        if (p_wvalid && !p_wready && !err_rise) begin
          chk("w_hold", bus.ms_wvalid, 1);
          chk("w_data_stable", bus.SWM_wdata, p_data);
        end
        if (bus.ms_arvalid && bus.sm_arready) begin
          if (exp_q.size() == 0) fail_now("unexpected_read");
          else begin
            t = exp_q.pop_front();
            chk("rd_kind", t.is_wr, 0);
            chk("rd_addr", bus.SWM_arADDR, t.addr);
          end
          last_wr = 0;
        end
        if (bus.ms_awvalid && bus.sm_awready) begin
          if (exp_q.size() == 0) fail_now("unexpected_write_addr");
          else begin
            chk("wr_kind", exp_q[0].is_wr, 1);
            chk("wr_addr", bus.SWM_arADDR, exp_q[0].addr);
            seen_aw = 1;
          end
          last_wr = 1;
        end
        if (bus.ms_wvalid && bus.sm_wready) begin
          if (exp_q.size() == 0) fail_now("unexpected_write_data");
          else begin
            chk("wr_data", bus.SWM_wdata, exp_q[0].data);
            seen_w = 1;
          end
        end
        if (seen_aw && seen_w && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          seen_aw = 0;
          seen_w  = 0;
        end
        if (busy && !p_busy) rise_cyc = cyc;
        if (done) begin
          done_cnt++;
          if (slave_mode == 1) chk("done_latency", cyc - rise_cyc, last_wr ? 1 : 2);
        end
        if (p_done) chk("idle_after_done", busy, 0);
        if (!bus.ms_awvalid && bus.ms_wvalid) aw_first = 1;
        if (bus.ms_arvalid) ar_hi_cnt = p_arvalid ? ar_hi_cnt + 1 : 1;
        if (err_rise) ar_run = ar_hi_cnt;
        p_arvalid = bus.ms_arvalid; p_arready = bus.sm_arready;
        p_rready  = bus.ms_rready;  p_rvalid  = bus.sm_rvalid;
        p_awvalid = bus.ms_awvalid; p_awready = bus.sm_awready;
        p_wvalid  = bus.ms_wvalid;  p_wready  = bus.sm_wready;
        p_addr = bus.SWM_arADDR; p_data = bus.SWM_wdata;
        p_done = done; p_busy = busy; p_err = err;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    int n;
    tick(3);
    chk("rst_arvalid", bus.ms_arvalid, 0);
    chk("rst_rready", bus.ms_rready, 0);
    chk("rst_awvalid", bus.ms_awvalid, 0);
    chk("rst_wvalid", bus.ms_wvalid, 0);
    chk("rst_addr", bus.SWM_arADDR, 0);
    chk("rst_wdata", bus.SWM_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    tick(2);

    // Read with ready high.
    slave_mode = 1;
    d0 = done_cnt;
    press(1, 0, 4'd3, 4'd0, 1);
    chk("read_done_pulses", done_cnt - d0, 1);

    // Write where the data channel lags the address channel.
    slave_mode = 3;
    aw_first = 0;
    d0 = done_cnt;
    press(0, 1, 4'd3, 4'd4, 1);
    chk("stagger_aw_first", aw_first, 1);
    chk("stagger_done_pulses", done_cnt - d0, 1);

    // Bouncing read button: only the final stable press counts.
    slave_mode = 0;
    d0 = done_cnt;
    begin
      txn_t t;
      t.is_wr = 0; t.addr = 4'd9; t.data = '0;
      exp_q.push_back(t);
      exp_done++;
    end
    sw_addr = 4'd9;
    for (int i = 0; i < 10; i++) begin
      btn_rd = ~btn_rd;
      tick(2);
    end
    btn_rd = 1'b1;
    tick(DEB + 8);
    btn_rd = 1'b0;
    tick(DEB + 4);
    wait_idle();
    chk("bounce_done_pulses", done_cnt - d0, 1);

    // Simultaneous presses: read first, then the captured write.
    slave_mode = 1;
    d0 = done_cnt;
    press(1, 1, 4'd12, 4'd10, 1);
    chk("simul_done_pulses", done_cnt - d0, 2);

    // Randomized traffic against a randomly stalling slave.
    slave_mode = 0;
    for (int i = 0; i < 12; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      press(kind != 1, kind != 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1);
    end

`ifdef AXI_SW_MASTER_TIMEOUT_EN
    slave_mode = 4;
    d0 = done_cnt;
    press(1, 0, 4'd7, 4'd0, 0);
    chk("tmo_ar_cycles", ar_run, TMO);
    chk("tmo_err", err, 1);
    chk("tmo_no_done", done_cnt - d0, 0);
    slave_mode = 1;
    press(0, 1, 4'd2, 4'd5, 1);
    chk("tmo_err_cleared", err, 0);
`else
    // A read press during a stalled write is dropped.
    slave_mode = 2;
    d0 = done_cnt;
    begin
      txn_t t;
      t.is_wr = 1; t.addr = 4'd5; t.data = 4'd9;
      exp_q.push_back(t);
      exp_done++;
    end
    sw_addr = 4'd5;
    sw_data = 4'd9;
    btn_wr = 1'b1;
    tick(DEB + 8);
    btn_wr = 1'b0;
    chk("stall_busy", busy, 1);
    sw_addr = 4'd6;
    btn_rd = 1'b1;
    tick(DEB + 8);
    btn_rd = 1'b0;
    tick(DEB + 4);
    slave_mode = 0;
    wait_idle();
    chk("drop_done_pulses", done_cnt - d0, 1);
`endif

    // Reset in the middle of a stalled write.
    slave_mode = 2;
    d0 = done_cnt;
    sw_addr = 4'd1;
    sw_data = 4'd2;
    btn_wr = 1'b1;
    n = 0;
    while (!busy && n < 40) begin
      tick(1);
      n++;
    end
    if (!busy) fail_now("reset_test_start");
    btn_wr = 1'b0;
    tick(2);
    chk("pre_reset_awvalid", bus.ms_awvalid, 1);
    reset = 1'b1;
    tick(1);
    chk("midrst_awvalid", bus.ms_awvalid, 0);
    chk("midrst_wvalid", bus.ms_wvalid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    reset = 1'b0;
    slave_mode = 1;
    tick(DEB + 6);
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_idle", busy, 0);

    chk("queue_drained", exp_q.size(), 0);
    chk("done_total", done_cnt, exp_done);
    chk("final_err", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_sw_master.md
# axi_sw_master

Switch/button-driven AXI-lite-style master that sits directly upstream of the `axi` register slave. It debounces two push-buttons, latches the 4-bit address/data switches, and issues one read or one write transaction per press using the slave's `ms_*`/`sm_*` valid/ready handshake. The slave shows read results on its own hex display; this block only sequences transactions and reports status.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles before a button level is accepted.
- `TIMEOUT_CYCLES`, default 1024: maximum cycles waiting in any handshake state (used only with the timeout feature).
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `btn_rd`  in  1  raw read button, asynchronous, bouncing.
- `btn_wr`  in  1  raw write button, asynchronous, bouncing.
- `sw_addr`  in  4  address switches.
- `sw_data`  in  4  write-data switches.
- `ms_arvalid`  out  1  read address valid.
- `sm_arready`  in  1  read address ready.
- `ms_rready`  out  1  read data ready.
- `sm_rvalid`  in  1  read data valid.
- `ms_awvalid`  out  1  write address valid.
- `sm_awready`  in  1  write address ready.
- `ms_wvalid`  out  1  write data valid.
- `sm_wready`  in  1  write data ready.
- `SWM_arADDR`  out  4  transaction address, shared by reads and writes.
- `SWM_wdata`  out  4  write data.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse when a transaction completes.
- `err`  out  1  sticky timeout flag.

## Operation
- Button path:
  - Two-flop synchronizer, then debounce.
  - Rising-edge detect produces a one-cycle `rd_req`/`wr_req`.
- IDLE:
  - On `rd_req`: latch `sw_addr` into `SWM_arADDR`, go to RD_ADDR.
  - On `wr_req`: latch `sw_addr` into `SWM_arADDR` and `sw_data` into `SWM_wdata`, go to WR.
  - Accepting any request clears `err`.
- Simultaneous `rd_req` and `wr_req`:
  - Read is taken first.
  - Write is held in `wr_pend`, with its address/data captured at that moment.
  - The pending write is issued from IDLE on the cycle after the read's DONE.
- Requests arriving while `busy` and not simultaneous with acceptance are dropped.
- RD_ADDR: `ms_arvalid`=1 until `ms_arvalid && sm_arready` at an edge, then go to RD_DATA.
- RD_DATA: `ms_rready`=1 until `sm_rvalid` at an edge, then go to DONE.
- WR:
  - `ms_awvalid` and `ms_wvalid` assert together.
  - Each drops independently after its own handshake, tracked in `aw_done`/`w_done`.
  - When both are done, go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Valid signals never drop before their handshake, except on timeout or reset.
- `SWM_arADDR`/`SWM_wdata` stay stable from valid assertion until the handshake.

## Timing
- Reset values:
  - All valid/ready outputs, `busy`, `done`, `err` = 0.
  - `SWM_arADDR` = 0, `SWM_wdata` = 0, state = IDLE.
  - `wr_pend` = 0, debounce counters = 0.
- Reset mid-transaction: all valids drop on the next edge; no `done` pulse.
- Button latency: press stable at cycle t gives `rd_req` at t+2+`DEBOUNCE_CYCLES`.
- Valid assertion: valid rises one cycle after request acceptance.
- Handshake timing:
  - If ready is already high, the handshake completes at the first edge with valid high.
  - Valid falls on the following cycle.
- Minimum cycles, acceptance to `done` pulse, with ready tied high: read = 3, write = 2.
- Debounce counter saturates and does not wrap; it resets on any input change.

## Configuration
- `AXI_SW_MASTER_TIMEOUT_EN` defined:
  - A per-state counter restarts on entering RD_ADDR, RD_DATA or WR.
  - After `TIMEOUT_CYCLES` cycles without completing the state, all valid/ready outputs drop and the state goes to IDLE.
  - `err` sets to 1 and `wr_pend` clears.
  - No `done` pulse.
- Not defined: no counter; the block waits indefinitely and `err` stays 0.

## Structure
- Package `axi_sw_pkg`:
  - State enum (IDLE, RD_ADDR, RD_DATA, WR, DONE).
  - `ADDR_W`=4, `DATA_W`=4.
  - Timeout counter width function.
- Sub-module `sw_debounce`, instantiated twice: synchronizer, stable counter and rising-edge pulse output.

## Test plan
All cases use `DEBOUNCE_CYCLES`=4 and `TIMEOUT_CYCLES`=8.
- Read, ready high: `sw_addr`=3, `btn_rd` pulse -> `ms_arvalid` one cycle with `SWM_arADDR`=3, then `ms_rready` until `sm_rvalid`, `done` pulse, `busy` low.
- Write with staggered readies: `sw_addr`=3, `sw_data`=4, `btn_wr`; `sm_wready` 2 cycles after `sm_awready` -> `ms_awvalid` falls first, `ms_wvalid` holds, data stays 4, one `done`.
- Bounce: `btn_rd` toggled every 2 cycles for 20 cycles, then held high -> exactly one read issued.
- Simultaneous: `btn_rd` and `btn_wr` edges on the same cycle -> read completes, then write with the captured address/data, two `done` pulses.
- Timeout (with macro): `btn_rd`, `sm_arready` held 0 -> `ms_arvalid` drops after 8 cycles, `err`=1; next `btn_wr` clears `err`.
- Reset during WR with readies low -> valids 0 next cycle, state IDLE, no `done`.
